branch_predictor: RTL and testbench

Fetch-side branch predictor that consumes the execute stage's branch resolution stream (taken decision, resolved target) and turns it into next-PC predictions for fetch. It holds a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB). Fetch issues a lookup and receives a registered prediction one cycle later; exe writes one resolution per cycle. An internal walker clears the table after reset and on flush.

---
 rtl/drac_pkg.sv | 42 ++++
 rtl/bp_sat_counter.sv | 23 ++
 rtl/branch_predictor.sv | 200 ++++++++++++++++++++
 tb/tb_branch_predictor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared core types for the fetch-side branch predictor.
// Provides the PC type, the branch decision encoding, the predictor table entry
// and the predictor walker state enum.
package drac_pkg;

    localparam int unsigned BP_IDX_BITS = 6;
    localparam int unsigned BP_TAG_BITS = 8;
    localparam int unsigned BP_PC_WIDTH = 40;

    typedef logic [BP_PC_WIDTH-1:0] addrPC_t;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } branch_decision_t;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        addrPC_t                target;
        logic [1:0]             ctr;
    } bp_entry_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } bp_state_t;

    // Weakly not-taken, so a freshly cleared or allocated entry needs one
    // taken resolution before it predicts taken.
    localparam logic [1:0] BP_CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] BP_CTR_WEAK_T  = 2'b10;

    localparam bp_entry_t BP_ENTRY_CLEAR = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        ctr:    BP_CTR_WEAK_NT
    };

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational 2-bit saturating counter step.
// Ports:
//   i_ctr : current counter value
//   i_inc : 1 = increment (saturate at 2'b11), 0 = decrement (saturate at 2'b00)
//   o_ctr : next counter value
module bp_sat_counter (
    input  logic [1:0] i_ctr,
    input  logic       i_inc,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != 2'b11) begin
                o_ctr = i_ctr + 2'd1;
            end
        end else if (i_ctr != 2'b00) begin
            o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counter table with a tagged
// BTB. Lookups return a registered prediction one cycle later; exe writes one
// resolution per cycle. A walker clears the table after reset and on flush.
// Ports:
//   clk_i, rst_i (sync, active high), flush_i (full table clear)
//   lookup_valid_i/lookup_pc_i -> pred_valid_o/pred_taken_o/pred_target_o (+1 cycle)
//   ready_o : table usable (RUN state only)
//   upd_valid_i/upd_pc_i/upd_taken_i/upd_target_i : resolution stream from exe
// Optional: define BRANCH_PRED_STATS_EN to add stat_upd_o / stat_mispred_o.
// TAG_BITS and PC_WIDTH must match the drac_pkg entry layout.
module branch_predictor
    import drac_pkg::*;
#(
    parameter int unsigned IDX_BITS = BP_IDX_BITS,
    parameter int unsigned TAG_BITS = BP_TAG_BITS,
    parameter int unsigned PC_WIDTH = BP_PC_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                lookup_valid_i,
    input  logic [PC_WIDTH-1:0] lookup_pc_i,
    output logic                pred_valid_o,
    output branch_decision_t    pred_taken_o,
    output logic [PC_WIDTH-1:0] pred_target_o,
    output logic                ready_o,
`ifdef BRANCH_PRED_STATS_EN
    output logic [31:0]         stat_upd_o,
    output logic [31:0]         stat_mispred_o,
`endif
    input  logic                upd_valid_i,
    input  logic [PC_WIDTH-1:0] upd_pc_i,
    input  branch_decision_t    upd_taken_i,
    input  logic [PC_WIDTH-1:0] upd_target_i
);

    localparam int unsigned Entries = 2 ** IDX_BITS;

    bp_entry_t             r_table [Entries];
    bp_state_t             r_state;
    bp_state_t             w_state_next;
    logic [IDX_BITS-1:0]   r_walk_idx;
    logic [IDX_BITS-1:0]   w_walk_idx_next;

    logic                  r_pred_valid;
    branch_decision_t      r_pred_taken;
    logic [PC_WIDTH-1:0]   r_pred_target;

    logic [IDX_BITS-1:0]   w_lk_idx;
    logic [TAG_BITS-1:0]   w_lk_tag;
    bp_entry_t             w_lk_entry;
    logic                  w_lk_taken;
    logic                  w_lookup_acc;

    logic [IDX_BITS-1:0]   w_up_idx;
    logic [TAG_BITS-1:0]   w_up_tag;
    bp_entry_t             w_up_entry;
    bp_entry_t             w_up_new;
    logic                  w_up_hit;
    logic                  w_upd_en;
    logic [1:0]            w_ctr_step;
    logic                  w_run;
    logic                  w_unused;

    assign w_run    = (r_state == RUN);
    assign ready_o  = w_run;

    assign w_lk_idx   = lookup_pc_i[IDX_BITS+1:2];
    assign w_lk_tag   = lookup_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign w_lk_entry = r_table[w_lk_idx];
    assign w_lk_taken = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag) && w_lk_entry.ctr[1];
    assign w_lookup_acc = lookup_valid_i && w_run;

    assign w_up_idx   = upd_pc_i[IDX_BITS+1:2];
    assign w_up_tag   = upd_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign w_up_entry = r_table[w_up_idx];
    assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);
    // Flush wins over a same-cycle update.
    assign w_upd_en   = upd_valid_i && w_run && !flush_i;

    assign w_unused = ^{upd_pc_i[1:0], upd_pc_i[PC_WIDTH-1:IDX_BITS+TAG_BITS+2]};

    bp_sat_counter u_sat_counter (
        .i_ctr (w_up_entry.ctr),
        .i_inc (upd_taken_i == TAKEN),
        .o_ctr (w_ctr_step)
    );

    always_comb begin
        w_up_new       = w_up_entry;
        w_up_new.valid = 1'b1;
        w_up_new.tag   = w_up_tag;
        if (w_up_hit) begin
            w_up_new.ctr = w_ctr_step;
        end else begin
            w_up_new.ctr = (upd_taken_i == TAKEN) ? BP_CTR_WEAK_T : BP_CTR_WEAK_NT;
        end
        // Not-taken resolutions carry no useful target; keep the stored one.
        if (upd_taken_i == TAKEN) begin
            w_up_new.target = upd_target_i;
        end
    end

    // Walker FSM: INIT and FLUSH clear one entry per cycle, then hand over to RUN.
    always_comb begin
        w_state_next    = r_state;
        w_walk_idx_next = r_walk_idx;
        unique case (r_state)
            INIT, FLUSH: begin
                if (flush_i) begin
                    w_walk_idx_next = '0;
                end else if (r_walk_idx == '1) begin
                    w_state_next    = RUN;
                    w_walk_idx_next = '0;
                end else begin
                    w_walk_idx_next = r_walk_idx + 1'b1;
                end
            end
            RUN: begin
                if (flush_i) begin
                    w_state_next    = FLUSH;
                    w_walk_idx_next = '0;
                end
            end
            default: begin
                w_state_next    = INIT;
                w_walk_idx_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= INIT;
            r_walk_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_walk_idx <= w_walk_idx_next;
        end
    end

    // Table storage carries no reset; the walker clears it before RUN.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (!w_run) begin
                r_table[r_walk_idx] <= BP_ENTRY_CLEAR;
            end else if (w_upd_en) begin
                r_table[w_up_idx] <= w_up_new;
            end
        end
    end

    // Prediction is formed from the pre-write table contents (read-before-write).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= NOT_TAKEN;
            r_pred_target <= '0;
        end else begin
            r_pred_valid <= w_lookup_acc;
            if (w_lookup_acc) begin
                r_pred_taken  <= w_lk_taken ? TAKEN : NOT_TAKEN;
                r_pred_target <= w_lk_taken ? w_lk_entry.target
                                            : lookup_pc_i + PC_WIDTH'(4);
            end
        end
    end

    assign pred_valid_o  = r_pred_valid;
    assign pred_taken_o  = r_pred_taken;
    assign pred_target_o = r_pred_target;

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] r_stat_upd;
    logic [31:0] r_stat_mispred;
    logic        w_mispred;

    assign w_mispred = (upd_taken_i != ((w_up_hit && w_up_entry.ctr[1]) ? TAKEN : NOT_TAKEN))
                    || ((upd_taken_i == TAKEN) && (w_up_entry.target != upd_target_i));

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_upd     <= '0;
            r_stat_mispred <= '0;
        end else if (w_upd_en) begin
            r_stat_upd <= r_stat_upd + 32'd1;
            if (w_mispred) begin
                r_stat_mispred <= r_stat_mispred + 32'd1;
            end
        end
    end

    assign stat_upd_o     = r_stat_upd;
    assign stat_mispred_o = r_stat_mispred;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    import drac_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             lv = 1'b0;
    logic [39:0]      lpc = '0;
    logic             pred_valid;
    branch_decision_t pred_taken;
    logic [39:0]      pred_target;
    logic             ready;
    logic             uv = 1'b0;
    logic [39:0]      upc = '0;
    branch_decision_t ut = NOT_TAKEN;
    logic [39:0]      utgt = '0;
`ifdef BRANCH_PRED_STATS_EN
    logic [31:0]      stat_upd;
    logic [31:0]      stat_mispred;
`endif

    typedef struct packed {
        logic        taken;
        logic [39:0] target;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    branch_predictor u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .lookup_valid_i (lv),
        .lookup_pc_i    (lpc),
        .pred_valid_o   (pred_valid),
        .pred_taken_o   (pred_taken),
        .pred_target_o  (pred_target),
        .ready_o        (ready),
`ifdef BRANCH_PRED_STATS_EN
        .stat_upd_o     (stat_upd),
        .stat_mispred_o (stat_mispred),
`endif
        .upd_valid_i    (uv),
        .upd_pc_i       (upc),
        .upd_taken_i    (ut),
        .upd_target_i   (utgt)
    );

    // Scoreboard: every prediction must match the oldest pending expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            if (pred_valid === 1'b1) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL pred_unexpected: got pred_valid=1, want 0 (no lookup pending)");
                end else begin
                    e = sb_q.pop_front();
                    if (pred_taken !== e.taken || pred_target !== e.target) begin
                        bad++;
                        $display("FAIL pred: got taken=%0b target=%h, want taken=%0b target=%h",
                                 pred_taken, pred_target, e.taken, e.target);
                    end
                end
            end else if (sb_q.size() != 0) begin
                total++;
                bad++;
                e = sb_q.pop_front();
                $display("FAIL pred_missing: got pred_valid=%b, want 1 (taken=%0b target=%h)",
                         pred_valid, e.taken, e.target);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic l_v, input logic [39:0] l_pc, input logic u_v,
                         input logic [39:0] u_pc, input logic u_t, input logic [39:0] u_tgt,
                         input logic fl);
        @(negedge clk);
        lv    = l_v;
        lpc   = l_pc;
        uv    = u_v;
        upc   = u_pc;
        ut    = u_t ? TAKEN : NOT_TAKEN;
        utgt  = u_tgt;
        flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic lookup(input logic [39:0] pc, input logic exp_taken,
                          input logic [39:0] exp_target);
        exp_t e;
        drive(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0);
        e.taken  = exp_taken;
        e.target = exp_target;
        sb_q.push_back(e);
    endtask

    task automatic update(input logic [39:0] pc, input logic taken, input logic [39:0] tgt);
        drive(1'b0, '0, 1'b1, pc, taken, tgt, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 65; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rst    = 1'b0;
                mon_en = 1'b1;
                total++;
                if (pred_valid !== 1'b0 || pred_taken !== NOT_TAKEN || pred_target !== 40'h0) begin
                    bad++;
                    $display("FAIL reset_outputs: got v=%b t=%b tgt=%h, want v=0 t=0 tgt=0",
                             pred_valid, pred_taken, pred_target);
                end
            end
            total++;
            if (ready !== (i == 65)) begin
                bad++;
                $display("FAIL init_ready cycle %0d: got %b want %b", i, ready, (i == 65));
            end
            lv  = (i == 3);
            lpc = 40'h1000;
            if (i == 4) begin
                total++;
                if (pred_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL init_lookup_drop: got pred_valid=%b want 0", pred_valid);
                end
            end
        end
        lv = 1'b0;
    endtask

    task automatic test_cold();
        lookup(40'h1000, 1'b0, 40'h1004);
        idle();
    endtask

    task automatic test_train();
        update(40'h1000, 1'b1, 40'h2000);
        lookup(40'h1000, 1'b1, 40'h2000);
        idle();
    endtask

    task automatic test_counter();
        update(40'h1000, 1'b0, '0);                 // 10 -> 01
        lookup(40'h1000, 1'b0, 40'h1004);
        update(40'h1000, 1'b0, '0);                 // 01 -> 00
        update(40'h1000, 1'b0, '0);                 // 00 stays
        lookup(40'h1000, 1'b0, 40'h1004);
        update(40'h1000, 1'b1, 40'h3000);           // 00 -> 01
        lookup(40'h1000, 1'b0, 40'h1004);
        update(40'h1000, 1'b1, 40'h3000);           // 01 -> 10
        lookup(40'h1000, 1'b1, 40'h3000);
        update(40'h1000, 1'b1, 40'h3000);           // 10 -> 11
        update(40'h1000, 1'b1, 40'h3000);           // 11 stays
        update(40'h1000, 1'b0, '0);                 // 11 -> 10
        lookup(40'h1000, 1'b1, 40'h3000);
        update(40'h1000, 1'b0, '0);                 // 10 -> 01
        lookup(40'h1000, 1'b0, 40'h1004);
        update(40'h1000, 1'b1, 40'h3000);           // 01 -> 10
        idle();
    endtask

    task automatic test_alias();
        exp_t e;
        lookup(40'h1100, 1'b0, 40'h1104);           // same index, different tag
        // Same-cycle lookup and update: prediction sees the old entry.
        drive(1'b1, 40'h1000, 1'b1, 40'h1000, 1'b0, '0, 1'b0);
        e.taken  = 1'b1;
        e.target = 40'h3000;
        sb_q.push_back(e);
        lookup(40'h1000, 1'b0, 40'h1004);           // update landed: 10 -> 01
        update(40'h1100, 1'b1, 40'h5000);           // allocate over 0x1000
        lookup(40'h1100, 1'b1, 40'h5000);
        lookup(40'h1000, 1'b0, 40'h1004);
        update(40'h1200, 1'b0, '0);                 // allocate NT -> 01
        update(40'h1200, 1'b0, '0);                 // 01 -> 00
        update(40'h1200, 1'b1, 40'h6000);           // 00 -> 01
        lookup(40'h1200, 1'b0, 40'h1204);
        update(40'h1300, 1'b1, 40'h7000);           // allocate T -> 10
        update(40'h1300, 1'b0, '0);                 // 10 -> 01
        lookup(40'h1300, 1'b0, 40'h1304);
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 64; i++) begin
            update(40'h4000 + 40'(i * 4), 1'b1, 40'h8000 + 40'(i * 4));
        end
        for (int i = 0; i < 64; i++) begin
            lookup(40'h4000 + 40'(i * 4), 1'b1, 40'h8000 + 40'(i * 4));
        end
        idle();
    endtask

    task automatic walk_check(input string name);
        for (int i = 1; i <= 65; i++) begin
            @(negedge clk);
            lv    = (i == 2);
            lpc   = 40'h4000;
            uv    = 1'b0;
            flush = 1'b0;
            total++;
            if (ready !== (i == 65)) begin
                bad++;
                $display("FAIL %s_ready cycle %0d: got %b want %b", name, i, ready, (i == 65));
            end
            if (i == 3) begin
                total++;
                if (pred_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_lookup_drop: got pred_valid=%b want 0", name, pred_valid);
                end
            end
        end
        lv = 1'b0;
    endtask

    task automatic test_flush();
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_pre_ready: got %b want 1", ready);
        end
        drive(1'b0, '0, 1'b1, 40'h4000, 1'b0, '0, 1'b1);
        walk_check("flush");
        for (int i = 0; i < 64; i++) begin
            lookup(40'h4000 + 40'(i * 4), 1'b0, 40'h4004 + 40'(i * 4));
        end
        lookup(40'hFF_FFFF_FFFC, 1'b0, 40'h0);
        idle();
    endtask

    task automatic test_flush_restart();
        update(40'h1000, 1'b1, 40'h2000);
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        repeat (5) idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        walk_check("restart");
        lookup(40'h1000, 1'b0, 40'h1004);
        idle();
    endtask

    initial begin
        test_reset();
        test_cold();
        test_train();
        test_counter();
        test_alias();
        test_back_to_back();
        test_flush();
        test_flush_restart();
        repeat (3) idle();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
